// File: rtl/pr_free_list_gen.sv
// pr_free_list_gen: circular free list of physical register numbers with a checkpointable head.
// Define FREELIST_DUP_CHECK_EN to build the free bitmap that drives err_dup_free.
module pr_free_list_gen #(
    parameter int NUM_PR  = 64,
    parameter int NUM_AR  = 16,
    parameter int ALLOC_W = 4,
    parameter int FREE_W  = 4,
    localparam int PRW  = $clog2(NUM_PR),
    localparam int PTRW = PRW + 1,
    localparam int CNTW = PRW + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [PTRW-1:0]       flush_head,
    input  logic [ALLOC_W-1:0]    alloc_req,
    output logic                  alloc_ok,
    output logic [ALLOC_W*PRW-1:0] alloc_pr,
    input  logic [FREE_W-1:0]     free_vld,
    input  logic [FREE_W*PRW-1:0] free_pr,
    output logic [CNTW-1:0]       free_cnt,
    output logic [PTRW-1:0]       curr_head,
    output logic                  list_empty,
    output logic                  err_dup_free
);
    logic [PRW-1:0]  list_q [NUM_PR];
    logic [PRW-1:0]  list_d [NUM_PR];
    logic [PTRW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNTW-1:0] a_off [ALLOC_W];
    logic [CNTW-1:0] f_off [FREE_W];
    logic [CNTW-1:0] a_cnt, f_cnt;

    // Lane offsets compact the sparse request/valid vectors onto consecutive slots.
    always_comb begin
        a_cnt = '0;
        for (int k = 0; k < ALLOC_W; k++) begin
            a_off[k] = a_cnt;
            a_cnt = a_cnt + CNTW'(alloc_req[k]);
        end
        f_cnt = '0;
        for (int k = 0; k < FREE_W; k++) begin
            f_off[k] = f_cnt;
            f_cnt = f_cnt + CNTW'(free_vld[k]);
        end
    end

    assign free_cnt   = tail_q - head_q;
    assign curr_head  = head_q;
    assign alloc_ok   = free_cnt >= a_cnt;
    assign list_empty = free_cnt < CNTW'(ALLOC_W);

    always_comb begin
        alloc_pr = '0;
        for (int k = 0; k < ALLOC_W; k++)
            if (alloc_req[k]) alloc_pr[k*PRW +: PRW] = list_q[PRW'(head_q + a_off[k])];
    end

    always_comb begin
        list_d = list_q;
        for (int k = 0; k < FREE_W; k++)
            if (free_vld[k]) list_d[PRW'(tail_q + f_off[k])] = free_pr[k*PRW +: PRW];
        tail_d = tail_q + f_cnt;
        head_d = flush ? flush_head : alloc_ok ? head_q + a_cnt : head_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= PTRW'(NUM_AR);
            tail_q <= PTRW'(NUM_PR);
            for (int i = 0; i < NUM_PR; i++) list_q[i] <= PRW'(i);
        end else if (!stall) begin
            head_q <= head_d;
            tail_q <= tail_d;
            list_q <= list_d;
        end
    end

`ifdef FREELIST_DUP_CHECK_EN
    logic [NUM_PR-1:0] fb_q, fb_d;
    logic [PTRW-1:0]   rb_cnt;
    logic              dup_d, err_q;

    // A flush hands the squashed allocations [flush_head, head) back as free.
    always_comb begin
        fb_d   = fb_q;
        dup_d  = 1'b0;
        rb_cnt = head_q - flush_head;
        if (flush) begin
            for (int j = 0; j < NUM_PR; j++)
                if (PTRW'(j) < rb_cnt) fb_d[list_q[PRW'(flush_head + PTRW'(j))]] = 1'b1;
        end else if (alloc_ok) begin
            for (int k = 0; k < ALLOC_W; k++)
                if (alloc_req[k]) fb_d[alloc_pr[k*PRW +: PRW]] = 1'b0;
        end
        for (int k = 0; k < FREE_W; k++) begin
            if (free_vld[k]) begin
                dup_d = dup_d | fb_q[free_pr[k*PRW +: PRW]];
                for (int m = 0; m < k; m++)
                    if (free_vld[m] && free_pr[m*PRW +: PRW] == free_pr[k*PRW +: PRW]) dup_d = 1'b1;
                fb_d[free_pr[k*PRW +: PRW]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_PR; i++) fb_q[i] <= (i >= NUM_AR);
            err_q <= 1'b0;
        end else if (!stall) begin
            fb_q  <= fb_d;
            err_q <= err_q | dup_d;
        end
    end

    assign err_dup_free = err_q;
`else
    assign err_dup_free = 1'b0;
`endif
endmodule

// File: tb/tb_pr_free_list_gen.sv
// tb_pr_free_list_gen: scoreboard bench for pr_free_list_gen against a queue-based free-pool model.
module tb_pr_free_list_gen;
    localparam int NPR = 64, NAR = 16, AW = 4, FW = 4, PRW = 6, PTRW = 7;
`ifdef FREELIST_DUP_CHECK_EN
    localparam bit DUP_EN = 1'b1;
`else
    localparam bit DUP_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst, stall, flush;
    logic [PTRW-1:0]   flush_head;
    logic [AW-1:0]     alloc_req;
    logic              alloc_ok;
    logic [AW*PRW-1:0] alloc_pr;
    logic [FW-1:0]     free_vld;
    logic [FW*PRW-1:0] free_pr;
    logic [PTRW-1:0]   free_cnt, curr_head;
    logic              list_empty, err_dup_free;

    always #5 clk = ~clk;

    pr_free_list_gen #(.NUM_PR(NPR), .NUM_AR(NAR), .ALLOC_W(AW), .FREE_W(FW)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .flush_head(flush_head),
        .alloc_req(alloc_req), .alloc_ok(alloc_ok), .alloc_pr(alloc_pr),
        .free_vld(free_vld), .free_pr(free_pr), .free_cnt(free_cnt),
        .curr_head(curr_head), .list_empty(list_empty), .err_dup_free(err_dup_free)
    );

    typedef struct {
        logic        ok, empty, err;
        logic [6:0]  cnt, head;
        logic [23:0] pr, msk;
    } exp_t;

    exp_t sb[$];
    int   fq[$];     // free PRs, front is next to allocate
    int   since[$];  // PRs allocated since the checkpoint, oldest first
    int   ret[$];    // in-use PRs the bench may legally retire
    int   mhead, chk_head;
    bit   merr;
    int   tests = 0, fails = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("alloc_ok", 32'(alloc_ok), 32'(e.ok));
            chk("alloc_pr", 32'(alloc_pr & e.msk), 32'(e.pr & e.msk));
            chk("free_cnt", 32'(free_cnt), 32'(e.cnt));
            chk("curr_head", 32'(curr_head), 32'(e.head));
            chk("list_empty", 32'(list_empty), 32'(e.empty));
            chk("err_dup_free", 32'(err_dup_free), 32'(e.err));
        end
    end

    function automatic bit in_fq(input int p);
        foreach (fq[i]) if (fq[i] == p) return 1'b1;
        return 1'b0;
    endfunction

    task automatic reset_model();
        fq.delete(); since.delete(); ret.delete();
        for (int i = NAR; i < NPR; i++) fq.push_back(i);
        for (int i = 0; i < NAR; i++) ret.push_back(i);
        mhead = NAR; chk_head = NAR; merr = 1'b0;
    endtask

    task automatic drop_ret(input int p);
        foreach (ret[i]) if (ret[i] == p) begin ret.delete(i); return; end
    endtask

    task automatic take_chk();
        foreach (since[i]) ret.push_back(since[i]);
        since.delete();
        chk_head = mhead;
    endtask

    task automatic step(input bit r, input bit st, input bit fl, input bit [3:0] ar,
                        input bit [3:0] fv, input bit [23:0] fp);
        exp_t e;
        int n = 0, off = 0;
        bit dup = 1'b0;
        rst = r; stall = st; flush = fl; flush_head = 7'(chk_head);
        alloc_req = ar; free_vld = fv; free_pr = fp;
        for (int k = 0; k < AW; k++) n += int'(ar[k]);
        e.ok = fq.size() >= n; e.cnt = 7'(fq.size()); e.head = 7'(mhead);
        e.empty = fq.size() < AW; e.err = merr; e.pr = '0; e.msk = '0;
        for (int k = 0; k < AW; k++) begin
            if (ar[k]) begin
                if (off < fq.size()) begin
                    e.msk[k*PRW +: PRW] = '1;
                    e.pr[k*PRW +: PRW] = 6'(fq[off]);
                end
                off++;
            end else e.msk[k*PRW +: PRW] = '1;
        end
        sb.push_back(e);
        @(posedge clk); #1;
        if (r) reset_model();
        else if (!st) begin
            for (int k = 0; k < FW; k++) begin
                if (fv[k]) begin
                    if (in_fq(int'(fp[k*PRW +: PRW]))) dup = 1'b1;
                    for (int m = 0; m < k; m++)
                        if (fv[m] && fp[m*PRW +: PRW] == fp[k*PRW +: PRW]) dup = 1'b1;
                end
            end
            merr = merr | (dup & DUP_EN);
            if (fl) begin
                for (int i = since.size() - 1; i >= 0; i--) fq.push_front(since[i]);
                since.delete();
                mhead = chk_head;
            end else if (fq.size() >= n) begin
                for (int i = 0; i < n; i++) since.push_back(fq.pop_front());
                mhead = (mhead + n) % (2 * NPR);
            end
            for (int k = 0; k < FW; k++) if (fv[k]) fq.push_back(int'(fp[k*PRW +: PRW]));
        end
    endtask

    task automatic rand_step(input bit r);
        bit st, fl;
        bit [3:0] fv;
        bit [23:0] fp;
        st = ($urandom % 10) == 0;
        fl = ($urandom % 16) == 0;
        fv = '0;
        fp = 24'($urandom);
        if (($urandom % 8) == 0) take_chk();
        for (int k = 0; k < FW; k++) begin
            if (($urandom % 2) == 1 && ret.size() > 0) begin
                int idx;
                idx = $urandom_range(0, ret.size() - 1);
                fp[k*PRW +: PRW] = 6'(ret[idx]);
                fv[k] = 1'b1;
                if (!st && !r) ret.delete(idx);
            end
        end
        step(r, st, fl, 4'($urandom), fv, fp);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; flush_head = '0;
        alloc_req = '0; free_vld = '0; free_pr = '0;
        @(posedge clk); #1;
        reset_model();
        step(0, 0, 0, 4'b1011, 4'b0000, 24'h0);
        step(0, 0, 0, 4'b0000, 4'b0000, 24'h0);
        // drain to empty, then a refused request, then free+alloc in one cycle
        step(1, 0, 0, 4'b0000, 4'b0000, 24'h0);
        repeat (12) step(0, 0, 0, 4'b1111, 4'b0000, 24'h0);
        step(0, 0, 0, 4'b0001, 4'b0000, 24'h0);
        drop_ret(5); drop_ret(9);
        step(0, 0, 0, 4'b0011, 4'b0101, {6'd0, 6'd9, 6'd0, 6'd5});
        step(0, 0, 0, 4'b0011, 4'b0000, 24'h0);
        step(0, 0, 0, 4'b0000, 4'b0000, 24'h0);
        // flush back to the reset checkpoint while retiring PR 0
        step(1, 0, 0, 4'b0000, 4'b0000, 24'h0);
        repeat (2) step(0, 0, 0, 4'b1111, 4'b0000, 24'h0);
        drop_ret(0);
        step(0, 0, 1, 4'b1111, 4'b0001, 24'h0);
        step(0, 0, 0, 4'b1111, 4'b0000, 24'h0);
        step(0, 0, 0, 4'b0000, 4'b0000, 24'h0);
        repeat (4) step(0, 1, 0, 4'b1111, 4'b1111,
                        {6'(ret[3]), 6'(ret[2]), 6'(ret[1]), 6'(ret[0])});
        repeat (2) step(0, 0, 0, 4'b1111, 4'b0000, 24'h0);
        // double free of a PR that is already free
        step(1, 0, 0, 4'b0000, 4'b0000, 24'h0);
        step(0, 0, 0, 4'b0000, 4'b0001, 24'd20);
        repeat (3) step(0, 0, 0, 4'b0000, 4'b0000, 24'h0);
        step(1, 0, 0, 4'b0000, 4'b0000, 24'h0);
        step(0, 0, 0, 4'b0000, 4'b0000, 24'h0);
        for (int i = 0; i < 3000; i++) rand_step(i == 1500);
        step(0, 0, 0, 4'b0000, 4'b0000, 24'h0);
        @(negedge clk); #1;
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
